// File: rtl/floating_division.sv
// rtl/floating_division.sv - iterative binary32 divider, one restoring quotient bit per clock
module floating_division #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t          state_q;
  logic [4:0]      cnt_q;
  logic            sign_q;
  logic [7:0]      eb_q;
  logic [23:0]     bm_q;
  logic [24:0]     r_q;
  logic [24:0]     q_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            r_ge_d;
  logic [24:0]     r_sub_d;
  logic [24:0]     r_d;
  logic [7:0]      eb_d;
  logic [7:0]      exp_d;
  logic [22:0]     frac_d;

  // One restoring step and the operand/normalisation arithmetic
  always_comb begin
    r_ge_d  = (r_q >= {1'b0, bm_q});
    r_sub_d = r_q - {1'b0, bm_q};
    // After a subtract the remainder is below BM (< 2^24), otherwise R itself is below BM,
    // so dropping bit 24 before the shift never loses information.
    r_d     = r_ge_d ? {r_sub_d[23:0], 1'b0} : {r_q[23:0], 1'b0};
    eb_d    = A[30:23] - B[30:23] + 8'd127;
    if (q_q[24]) begin
      exp_d  = eb_q;
      frac_d = q_q[23:1];
    end else begin
      exp_d  = eb_q - 8'd1;
      frac_d = q_q[22:0];
    end
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      eb_q     <= '0;
      bm_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= A[31] ^ B[31];
            eb_q    <= eb_d;
            bm_q    <= {1'b1, B[22:0]};
            r_q     <= {2'b01, A[22:0]};
            q_q     <= '0;
            cnt_q   <= 5'd24;
            busy_q  <= 1'b1;
            state_q <= DIV;
          end
        end
        DIV: begin
          q_q <= {q_q[23:0], r_ge_d};
          r_q <= r_d;
          if (cnt_q == 5'd0) begin
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        NORM: begin
          result_q <= {sign_q, exp_d, frac_d};
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_floating_division.sv
// tb/tb_floating_division.sv - directed self-checking bench for floating_division
module tb_floating_division;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  floating_division #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one division; optionally pulse start with junk operands pulse_at cycles after acceptance.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input int pulse_at, input string tag);
    int lat;
    int busy_cnt;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (c == pulse_at) begin
        start = 1'b1;
        A = 32'h3F800000;
        B = 32'h40400000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, 26);
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_busy_cycles"}, busy_cnt, 26);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] b2b_a   [3];
    logic [31:0] b2b_b   [3];
    logic [31:0] b2b_exp [3];
    int          k_done;
    logic        seen;

    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;

    // reset state and idle
    #2;
    check("reset_state", {busy, done, 30'd0} | result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy || done || (result != 32'd0)) seen = 1'b1;
    end
    check("idle_quiet", {31'd0, seen}, 32'd0);

    // directed quotients
    run_div(32'h40C00000, 32'h40000000, 32'h40400000, 0, "six_by_two");
    run_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, "one_by_three");
    run_div(32'hC0F00000, 32'h40200000, 32'hC0400000, 0, "neg_sign");
    run_div(32'h3FC00000, 32'h3FC00000, 32'h3F800000, 0, "equal_mant");

    // start pulsed mid-DIV is ignored, and nothing follows the completion
    run_div(32'h40C00000, 32'h40000000, 32'h40400000, 10, "mid_pulse");
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy || done) seen = 1'b1;
    end
    check("mid_pulse_no_extra", {31'd0, seen}, 32'd0);

    // start held high, operands changing every cycle
    b2b_a[0] = 32'h40C00000; b2b_b[0] = 32'h40000000; b2b_exp[0] = 32'h40400000;
    b2b_a[1] = 32'h3F800000; b2b_b[1] = 32'h40400000; b2b_exp[1] = 32'h3EAAAAAA;
    b2b_a[2] = 32'hC0F00000; b2b_b[2] = 32'h40200000; b2b_exp[2] = 32'hC0400000;
    A = b2b_a[0];
    B = b2b_b[0];
    start = 1'b1;
    @(posedge clk); #1;
    k_done = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 27) begin
        A = b2b_a[1]; B = b2b_b[1];
      end else if (c == 54) begin
        A = b2b_a[2]; B = b2b_b[2];
      end else begin
        A = $urandom; B = $urandom;
      end
      @(posedge clk); #1;
      if (c == 26 || c == 53 || c == 80) begin
        check("b2b_done_pulse", {31'd0, done}, 32'd1);
        check("b2b_result", result, b2b_exp[k_done]);
        k_done++;
      end else if (done) begin
        check("b2b_done_unexpected", {31'd0, done}, 32'd0);
      end
    end
    start = 1'b0;
    check("b2b_completions", k_done, 3);
    for (int i = 0; i < 30; i++) @(posedge clk);
    #1;
    check("b2b_idle_after", {30'd0, busy, done}, 32'd0);

    // reset during DIV
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy || done) seen = 1'b1;
    end
    check("rst_no_done", {31'd0, seen}, 32'd0);
    run_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floating_division.md
# floating_division

Iterative single-precision (IEEE-754 binary32 layout) floating-point divider: computes result = A / B with a start/done handshake. It is the inverse-operation companion to the team's floating-point multiplier and shares its operand format and simplifications: hidden-1 always, truncation, no special cases. It produces one quotient bit per clock through a restoring divider, so it trades latency for area.

## Interface
- XLEN, 32, operand/result width; only 32 is supported (sign [31], exponent [30:23], fraction [22:0]).
- clk  input  1  rising-edge clock; the block uses this single clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  XLEN  dividend; sampled on the accepting edge only.
- B  input  XLEN  divisor; sampled on the accepting edge only.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  XLEN  quotient; holds its value until the next completion.

## Operation
- States are IDLE, DIV and NORM.
- IDLE:
  - start=1 at an edge latches the following, then moves to DIV with the bit counter at 24 and busy=1:
    - sign = A[31]^B[31].
    - Eb = A[30:23] - B[30:23] + 127, as 8-bit modulo-256.
    - AM = {1,A[22:0]}.
    - BM = {1,B[22:0]}.
    - 25-bit remainder R = AM.
  - start=0 means the block stays in IDLE.
- DIV, one edge per quotient bit i = 24 down to 0:
  - If R >= BM: q[i]=1 and R = (R-BM)<<1.
  - Otherwise: q[i]=0 and R = R<<1.
  - After i=0 the block moves to NORM.
  - The resulting Q = floor(AM*2^24/BM) lies in [2^23, 2^25).
  - R stays below 2^25 at all times.
- NORM (one edge):
  - If Q[24]=1: fraction = Q[23:1], exponent = Eb.
  - Otherwise: fraction = Q[22:0], exponent = Eb-1, as 8-bit modulo-256.
  - result = {sign, exponent, fraction}, done=1, busy=0, and the block returns to IDLE.
- Arithmetic rules:
  - Truncation only; no rounding.
  - No handling of zero, denormal, Inf or NaN: an exponent field of 0 still uses the hidden 1.
  - Exponent overflow and underflow wrap.
- start while busy is ignored; there is no queueing.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, busy=0, done=0, result=0, counter/Q/R cleared. An in-flight division is discarded, and no done follows it.
- Latency: start accepted at edge k gives the following:
  - busy=1 after edge k.
  - The DIV bits are computed at edges k+1..k+25.
  - NORM at edge k+26 sets done=1 and busy=0 together.
- done is high for exactly one cycle; it drops at edge k+27 unless re-asserted.
- Back-to-back operation: start=1 in the cycle where done=1 (state IDLE) is accepted at edge k+27. Throughput is one division per 27 cycles.
- Operands may change freely after the accepting edge without affecting the result.
- result changes only at a NORM edge or on reset.

## Test plan
- Reset then idle: rst pulsed, start=0 for 40 cycles. Required: result=0x00000000, done=0, busy=0 throughout.
- Exact quotient, ratio ≥1: A=0x40C00000 (6.0), B=0x40000000 (2.0), start one cycle. Required: done exactly 26 cycles after the accepting edge with result=0x40400000; busy high for exactly 26 cycles.
- Ratio <1 with truncation: A=0x3F800000, B=0x40400000. Required: result=0x3EAAAAAA (Q[24]=0 path).
- Sign and equal mantissas:
  - A=0xC0F00000 (-7.5), B=0x40200000 (2.5). Required: 0xC0400000.
  - Then A=B=0x3FC00000. Required: 0x3F800000.
- Handshake:
  - start held high continuously with new operands every cycle. Required: only the operands at each accepting edge are used; completions are 27 cycles apart.
  - start pulsed mid-DIV. Required: ignored.
- Reset mid-operation: start with 6.0/2.0, assert rst at DIV cycle 10. Required: busy/done/result=0 immediately, no done pulse afterward. A new 0x3F800000/0x40400000 then completes normally with 0x3EAAAAAA.
